// File: rtl/pwm_update_sequencer_if.sv
// Duty-request handshake and PWM register-write bus for pwm_update_sequencer.
// The master modport is the sequencer side; the slave modport is the requester/PWM side.
interface pwm_update_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [47:0] req_duty;
    logic [3:0]  pwm_addr;
    logic        pwm_write;
    logic [31:0] pwm_writedata;
    logic        pwm_irq;

    modport master (
        input  req_valid,
        input  req_duty,
        input  pwm_irq,
        output req_ready,
        output pwm_addr,
        output pwm_write,
        output pwm_writedata
    );

    modport slave (
        output req_valid,
        output req_duty,
        output pwm_irq,
        input  req_ready,
        input  pwm_addr,
        input  pwm_write,
        input  pwm_writedata
    );
endinterface

// File: rtl/pwm_update_sequencer.sv
// Programs a 3-phase PWM with dead-time compare pairs and waits for the period-boundary irq.
// Optional WAIT timeout with sticky err_timeout is enabled by defining PWM_SEQ_TIMEOUT_EN.
module pwm_update_sequencer #(
    parameter logic [15:0] MAXCTR   = 16'd1000,
    parameter logic [15:0] DEADTIME = 16'd8,
    parameter logic [23:0] TIMEOUT  = 24'd200000
) (
    input  logic                          clk,
    input  logic                          reset,
    pwm_update_sequencer_if.master        bus,
    output logic                          busy,
    output logic                          applied,
    output logic                          err_timeout
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 3;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CALC,
        S_WRITE,
        S_WAIT
    } state_t;

    state_t              state, state_d;
    logic [IW-1:0]       idx, idx_d;
    logic [47:0]         duty_q, duty_d;
    logic [5:0][DW-1:0]  vals, vals_d, calc;
    logic                ready_q, ready_d;
    logic                write_q, write_d;
    logic [3:0]          addr_q, addr_d;
    logic [DW-1:0]       data_q, data_d;
    logic                busy_q, busy_d;
    logic                applied_q, applied_d;
    logic                err_q, err_d;
`ifdef PWM_SEQ_TIMEOUT_EN
    logic [23:0]         cnt_q, cnt_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Returns {high, low} compare values for one phase duty.
    function automatic logic [31:0] edges(input logic [15:0] duty);
        logic [15:0] d;
        logic [16:0] sum;
        logic [15:0] lo;
        logic [15:0] hi;
        d   = (duty > MAXCTR) ? MAXCTR : duty;
        lo  = (d >= DEADTIME) ? (d - DEADTIME) : 16'd0;
        sum = {1'b0, d} + {1'b0, DEADTIME};
        hi  = sum[16] ? 16'hFFFF : sum[15:0];
        return {hi, lo};
    endfunction

    // Init table: counter top, then update/irq only at counter zero.
    function automatic logic [19:0] init_entry(input logic [IW-1:0] i);
        case (i)
            3'd0:    return {4'h8, MAXCTR};
            3'd1:    return {4'hA, 16'd1};
            3'd2:    return {4'hB, 16'd0};
            3'd3:    return {4'hC, 16'd1};
            3'd4:    return {4'hD, 16'd0};
            default: return 20'd0;
        endcase
    endfunction

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            {calc[2*p+1], calc[2*p]} = edges(duty_q[16*p +: 16]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            idx       <= '0;
            duty_q    <= '0;
            vals      <= '0;
            ready_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b1;
            applied_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef PWM_SEQ_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            duty_q    <= duty_d;
            vals      <= vals_d;
            ready_q   <= ready_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            applied_q <= applied_d;
            err_q     <= err_d;
`ifdef PWM_SEQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Outputs are computed for the cycle being entered and registered with the state.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        duty_d    = duty_q;
        vals_d    = vals;
        ready_d   = 1'b0;
        write_d   = 1'b0;
        addr_d    = '0;
        data_d    = '0;
        applied_d = 1'b0;
        err_d     = err_q;
`ifdef PWM_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state)
            S_INIT: begin
                if (idx == IW'(5)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    write_d          = 1'b1;
                    {addr_d, data_d} = init_entry(idx);
                    idx_d            = idx + IW'(1);
                end
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    duty_d  = bus.req_duty;
                    state_d = S_CALC;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_CALC: begin
                vals_d  = calc;
                write_d = 1'b1;
                addr_d  = 4'h0;
                data_d  = calc[0];
                idx_d   = IW'(1);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx == IW'(7)) begin
                    state_d = S_WAIT;
                    idx_d   = '0;
`ifdef PWM_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (idx == IW'(6)) begin
                    write_d = 1'b1;
                    addr_d  = 4'hF;
                    data_d  = 16'd1;
                    idx_d   = IW'(7);
                end else begin
                    write_d = 1'b1;
                    addr_d  = 4'(idx);
                    case (idx)
                        3'd1:    data_d = vals[1];
                        3'd2:    data_d = vals[2];
                        3'd3:    data_d = vals[3];
                        3'd4:    data_d = vals[4];
                        3'd5:    data_d = vals[5];
                        default: data_d = vals[0];
                    endcase
                    idx_d = idx + IW'(1);
                end
            end
            S_WAIT: begin
                if (bus.pwm_irq) begin
                    applied_d = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = S_IDLE;
                end
`ifdef PWM_SEQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT - 24'd1) begin
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
`endif
            end
            default: begin
                state_d = S_INIT;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign bus.req_ready     = ready_q;
    assign bus.pwm_write     = write_q;
    assign bus.pwm_addr      = addr_q;
    assign bus.pwm_writedata = {16'h0, data_q};
    assign busy              = busy_q;
    assign applied           = applied_q;
    assign err_timeout       = err_q;

endmodule
